uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the UART path: the companion of `uart_tx` on the far end of the link. It samples the asynchronous serial line with an oversampling clock, recovers 8N1 frames (idle high, start bit 0, 8 data bits LSB first, stop bit 1) and presents each received byte as a parallel word with a one-cycle valid strobe. It detects false starts (glitches) and framing errors.

## Interface
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit. Must be even and at least 4. `clk` runs at `CLKS_PER_BIT` × baud.
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `rx_data` input 1: serial line, asynchronous to `clk`, idle high.
- `data_out` output 8: last correctly received byte. Held until the next good frame.
- `rx_valid` output 1: one-cycle pulse; `data_out` is new in that cycle.
- `rx_frame_err` output 1: one-cycle pulse; stop bit sampled low.
- `rx_busy` output 1: high in every state except IDLE.

## Operation
- Synchronizer: 2-flop synchronizer on `rx_data` gives `rx_sync`. Both flops reset to 1. The FSM uses only `rx_sync`.
- Counter: `cnt` is `$clog2(CLKS_PER_BIT)` bits wide. `bit_idx` is 3 bits. `shift` is an 8-bit register.
- HALF = `CLKS_PER_BIT`/2.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - `rx_sync`==0 → START, `cnt`=0.
  - Otherwise stay.
- START:
  - `cnt`≠HALF−1 → `cnt`++.
  - `cnt`==HALF−1 is the mid-start sample point:
    - `rx_sync`==0 → DATA, `cnt`=0, `bit_idx`=0.
    - `rx_sync`==1 → false start, back to IDLE. No output pulse.
- DATA:
  - `cnt`≠`CLKS_PER_BIT`−1 → `cnt`++.
  - At `CLKS_PER_BIT`−1: `shift[bit_idx]`←`rx_sync` (LSB first), `cnt`=0.
    - `bit_idx`==7 → STOP.
    - Otherwise `bit_idx`++.
- STOP: count to `CLKS_PER_BIT`−1, then sample.
  - `rx_sync`==1 → `data_out`←`shift`, `rx_valid`=1 for one cycle, → IDLE.
  - `rx_sync`==0 → `rx_frame_err`=1 for one cycle. `data_out` unchanged. → WAIT_IDLE.
- WAIT_IDLE:
  - Stay while `rx_sync`==0. This covers break conditions: no new start is detected until the line returns high.
  - `rx_sync`==1 → IDLE.
- No backpressure. A byte not consumed before the next `rx_valid` is overwritten.
- `rx_valid` and `rx_frame_err` are never high in the same cycle.
- Illegal or unused FSM encodings → IDLE.

## Timing
- Reset values:
  - `data_out`=8'h00, `rx_valid`=0, `rx_frame_err`=0, `rx_busy`=0.
  - FSM=IDLE, `cnt`=0, `bit_idx`=0, `shift`=0.
  - Sync flops=1.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronous), with no pulse. After release, the partial frame's remaining bits are treated as line activity. A remaining low level may start a new frame, which the bench must tolerate; no spurious `rx_valid` occurs before a full 10-bit frame.
- Sampling schedule. Let edge A be the first rising edge at which sync flop 1 captures the start-bit 0.
  - The FSM enters START at edge A+2.
  - The start bit is sampled at A+2+HALF.
  - Data bit i is sampled at A+2+HALF+(i+1)·`CLKS_PER_BIT`.
  - The stop bit is sampled at A+2+HALF+9·`CLKS_PER_BIT`.
  - `rx_valid` (or `rx_frame_err`) is high for the cycle after that edge.
  - For `CLKS_PER_BIT`=16, this is edge A+154.
- Back-to-back frames: the FSM re-enters IDLE at mid-stop-bit. A start bit immediately following the stop bit (zero idle time) is received without loss.
- Glitch rejection: a low pulse shorter than HALF cycles seen on `rx_sync` causes no output.
- Sampling near mid-bit tolerates about ±(HALF−1)/`CLKS_PER_BIT` bit of accumulated baud mismatch over a frame.
- `rx_busy` rises the cycle after the FSM leaves IDLE and falls the cycle the FSM returns to IDLE.

## Test plan
- Single frame: `CLKS_PER_BIT`=16, drive 0x27 (bits 1,1,1,0,0,1,0,0 after the start bit, then stop 1). Required: `rx_valid` is a one-cycle pulse at edge A+154, `data_out`=8'h27, `rx_frame_err` never high.
- Back-to-back: frames 0x00, 0xFF, 0xA5 with zero idle between frames. Required: three `rx_valid` pulses exactly 160 cycles apart, with `data_out` = 0x00, 0xFF, 0xA5 in order.
- Glitch: drive `rx_data` low for 3 cycles while idle. Required: `rx_busy` pulses briefly, the FSM returns to IDLE, no `rx_valid`, no `rx_frame_err`, `data_out` unchanged.
- Framing error: receive 0x5A correctly, then a frame of 0x3C with stop bit 0, holding the line low for 40 more cycles. Required: one `rx_frame_err` pulse, no `rx_valid`, `data_out` stays 0x5A, `rx_busy` stays high until the line returns high. A following 0x81 frame is then received correctly.
- Reset mid-frame: assert `reset` during data bit 4 of a 0x96 frame. Required: all outputs are at reset values within the same cycle. After release and 20 idle-high cycles, a 0x3C frame yields `rx_valid` with `data_out`=0x3C.
- Parameter: `CLKS_PER_BIT`=8, drive 0xC3. Required: `rx_valid` at edge A+2+4+72=A+78, `data_out`=8'hC3.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 serial receiver.
// The line passes through a two-flop synchronizer, then an FSM times each bit
// from the detected start edge and samples it near mid-bit. Good frames
// update data_out with a one-cycle rx_valid strobe. A low stop bit gives a
// one-cycle rx_frame_err, and the receiver then waits for the line to return
// high before it looks for another start bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_data,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic [7:0]    r_dataOut;
  logic          r_valid;
  logic          r_frameErr;

  state_t        w_stateNext;
  logic [CW-1:0] w_cntNext;
  logic [2:0]    w_bitIdxNext;
  logic [7:0]    w_shiftNext;
  logic [7:0]    w_dataOutNext;
  logic          w_validNext;
  logic          w_frameErrNext;
  logic          w_rxSync;

  assign w_rxSync = r_sync2;

  // Bring the asynchronous line into the clk domain; idle level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_data;
      r_sync2 <= r_sync1;
    end
  end

  // State, bit timing and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bitIdx   <= 3'd0;
      r_shift    <= 8'h00;
      r_dataOut  <= 8'h00;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_bitIdx   <= w_bitIdxNext;
      r_shift    <= w_shiftNext;
      r_dataOut  <= w_dataOutNext;
      r_valid    <= w_validNext;
      r_frameErr <= w_frameErrNext;
    end
  end

  // Next-state logic: a half-bit delay lands sampling near mid-bit, then each
  // data and stop bit is sampled one full bit period after the previous one.
  always_comb begin
    w_stateNext    = r_state;
    w_cntNext      = r_cnt;
    w_bitIdxNext   = r_bitIdx;
    w_shiftNext    = r_shift;
    w_dataOutNext  = r_dataOut;
    w_validNext    = 1'b0;
    w_frameErrNext = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_rxSync) begin
          w_stateNext = ST_START;
          w_cntNext   = '0;
        end
      end

      ST_START: begin
        if (r_cnt != HALF_M1) begin
          w_cntNext = r_cnt + 1'b1;
        end else if (!w_rxSync) begin
          w_stateNext  = ST_DATA;
          w_cntNext    = '0;
          w_bitIdxNext = 3'd0;
        end else begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end
      end

      ST_DATA: begin
        if (r_cnt != BIT_M1) begin
          w_cntNext = r_cnt + 1'b1;
        end else begin
          w_shiftNext[r_bitIdx] = w_rxSync;
          w_cntNext             = '0;
          if (r_bitIdx == 3'd7) begin
            w_stateNext = ST_STOP;
          end else begin
            w_bitIdxNext = r_bitIdx + 3'd1;
          end
        end
      end

      ST_STOP: begin
        if (r_cnt != BIT_M1) begin
          w_cntNext = r_cnt + 1'b1;
        end else begin
          w_cntNext = '0;
          if (w_rxSync) begin
            w_dataOutNext = r_shift;
            w_validNext   = 1'b1;
            w_stateNext   = ST_IDLE;
          end else begin
            w_frameErrNext = 1'b1;
            w_stateNext    = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (w_rxSync) begin
          w_stateNext = ST_IDLE;
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  assign data_out     = r_dataOut;
  assign rx_valid     = r_valid;
  assign rx_frame_err = r_frameErr;
  assign rx_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 16 and 8 clocks per bit.
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       rxData16;
  logic       rxData8;
  logic [7:0] dataOut16;
  logic       rxValid16;
  logic       rxFrameErr16;
  logic       rxBusy16;
  logic [7:0] dataOut8;
  logic       rxValid8;
  logic       rxFrameErr8;
  logic       rxBusy8;

  int errors = 0;
  int checks = 0;
  int edgeCount = 0;

  int validEdge16[$];
  int validData16[$];
  int errEdge16[$];
  int validEdge8[$];
  int validData8[$];
  int errCount8 = 0;
  int overlapCount = 0;
  bit busySeen = 0;

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rxData16),
    .data_out    (dataOut16),
    .rx_valid    (rxValid16),
    .rx_frame_err(rxFrameErr16),
    .rx_busy     (rxBusy16)
  );

  uart_rx #(.CLKS_PER_BIT(8)) dut8 (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rxData8),
    .data_out    (dataOut8),
    .rx_valid    (rxValid8),
    .rx_frame_err(rxFrameErr8),
    .rx_busy     (rxBusy8)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Index of the most recent rising edge, stable when read at a falling edge.
  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Record every output pulse with the edge that launched it.
  always @(negedge clk) begin
    if (rxValid16) begin
      validEdge16.push_back(edgeCount);
      validData16.push_back(int'(dataOut16));
    end
    if (rxFrameErr16) errEdge16.push_back(edgeCount);
    if (rxValid16 && rxFrameErr16) overlapCount++;
    if (rxBusy16) busySeen = 1'b1;
    if (rxValid8) begin
      validEdge8.push_back(edgeCount);
      validData8.push_back(int'(dataOut8));
    end
    if (rxFrameErr8) errCount8++;
    if (rxValid8 && rxFrameErr8) overlapCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setLine(input int sel, input logic val);
    if (sel == 0) rxData16 = val;
    else rxData8 = val;
  endtask

  // Drive one full frame starting at the current falling edge; aEdge is the
  // rising edge at which the first synchronizer flop captures the start bit.
  task automatic applyStimulus(input int sel, input logic [7:0] b,
                               input logic stopVal, output int aEdge);
    int cpb;
    cpb = (sel == 0) ? 16 : 8;
    aEdge = edgeCount + 1;
    setLine(sel, 1'b0);
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      setLine(sel, b[i]);
      repeat (cpb) @(negedge clk);
    end
    setLine(sel, stopVal);
    repeat (cpb) @(negedge clk);
  endtask

  // Directed scenarios.
  initial begin
    int a0, a1, a2, base, errBase;
    logic [7:0] frames [3];
    frames[0] = 8'h00;
    frames[1] = 8'hFF;
    frames[2] = 8'hA5;

    reset    = 1'b1;
    rxData16 = 1'b1;
    rxData8  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset data_out", dataOut16, 8'h00);
    checkOutput("reset rx_valid", rxValid16, 1'b0);
    checkOutput("reset rx_frame_err", rxFrameErr16, 1'b0);
    checkOutput("reset rx_busy", rxBusy16, 1'b0);
    checkOutput("reset8 data_out", dataOut8, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Single frame 0x27.
    applyStimulus(0, 8'h27, 1'b1, a0);
    repeat (10) @(negedge clk);
    checkOutput("single count", validEdge16.size(), 1);
    checkOutput("single edge", validEdge16[0], a0 + 154);
    checkOutput("single data", validData16[0], 8'h27);
    checkOutput("single data_out", dataOut16, 8'h27);
    checkOutput("single no err", errEdge16.size(), 0);

    // Back-to-back frames, zero idle time.
    base = validEdge16.size();
    applyStimulus(0, frames[0], 1'b1, a0);
    applyStimulus(0, frames[1], 1'b1, a1);
    applyStimulus(0, frames[2], 1'b1, a2);
    setLine(0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("b2b count", validEdge16.size() - base, 3);
    if (validEdge16.size() - base == 3) begin
      checkOutput("b2b edge0", validEdge16[base], a0 + 154);
      checkOutput("b2b gap01", validEdge16[base+1] - validEdge16[base], 160);
      checkOutput("b2b gap12", validEdge16[base+2] - validEdge16[base+1], 160);
      for (int i = 0; i < 3; i++)
        checkOutput($sformatf("b2b data%0d", i), validData16[base+i], frames[i]);
    end

    // Glitch: 3-cycle low pulse while idle.
    base = validEdge16.size();
    busySeen = 1'b0;
    setLine(0, 1'b0);
    repeat (3) @(negedge clk);
    setLine(0, 1'b1);
    repeat (30) @(negedge clk);
    checkOutput("glitch busy pulse", busySeen, 1'b1);
    checkOutput("glitch busy low", rxBusy16, 1'b0);
    checkOutput("glitch no valid", validEdge16.size() - base, 0);
    checkOutput("glitch no err", errEdge16.size(), 0);
    checkOutput("glitch data_out", dataOut16, 8'hA5);

    // Framing error then recovery.
    base = validEdge16.size();
    errBase = errEdge16.size();
    applyStimulus(0, 8'h5A, 1'b1, a0);
    applyStimulus(0, 8'h3C, 1'b0, a1);
    repeat (40) @(negedge clk);
    checkOutput("ferr busy held", rxBusy16, 1'b1);
    setLine(0, 1'b1);
    repeat (6) @(negedge clk);
    checkOutput("ferr busy released", rxBusy16, 1'b0);
    checkOutput("ferr err count", errEdge16.size() - errBase, 1);
    if (errEdge16.size() - errBase == 1)
      checkOutput("ferr err edge", errEdge16[errBase], a1 + 154);
    checkOutput("ferr valid count", validEdge16.size() - base, 1);
    checkOutput("ferr data_out", dataOut16, 8'h5A);
    repeat (10) @(negedge clk);
    applyStimulus(0, 8'h81, 1'b1, a2);
    setLine(0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("recover valid count", validEdge16.size() - base, 2);
    checkOutput("recover data_out", dataOut16, 8'h81);

    // Reset during data bit 4 of a 0x96 frame.
    base = validEdge16.size();
    setLine(0, 1'b0);
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      setLine(0, (8'h96 >> i) & 8'h01);
      repeat (16) @(negedge clk);
    end
    setLine(0, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("pre-reset busy", rxBusy16, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("midreset data_out", dataOut16, 8'h00);
    checkOutput("midreset busy", rxBusy16, 1'b0);
    checkOutput("midreset valid", rxValid16, 1'b0);
    checkOutput("midreset err", rxFrameErr16, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    applyStimulus(0, 8'h3C, 1'b1, a0);
    setLine(0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("post-reset count", validEdge16.size() - base, 1);
    if (validEdge16.size() - base == 1) begin
      checkOutput("post-reset edge", validEdge16[base], a0 + 154);
      checkOutput("post-reset data", validData16[base], 8'h3C);
    end

    // Eight clocks per bit, 0xC3.
    applyStimulus(1, 8'hC3, 1'b1, a0);
    setLine(1, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("cpb8 count", validEdge8.size(), 1);
    if (validEdge8.size() == 1) begin
      checkOutput("cpb8 edge", validEdge8[0], a0 + 78);
      checkOutput("cpb8 data", validData8[0], 8'hC3);
    end
    checkOutput("cpb8 no err", errCount8, 0);
    checkOutput("no valid+err overlap", overlapCount, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
